// File: rtl/conv2_pkg.sv
// Shared definitions for the conv2 frame controller: geometry, derived sizes
// and the sequencer state encoding.
package conv2_pkg;

  localparam int WIDTH         = 13;
  localparam int HEIGHT        = 13;
  localparam int KSIZE         = 3;
  localparam int CH_IN         = 8;
  localparam int DRAIN_TIMEOUT = 64;

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int OW   = WIDTH - KSIZE + 1;
  localparam int OH   = HEIGHT - KSIZE + 1;
  localparam int NOUT = OW * OH;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AW = bits_for(NPIX);
  localparam int CW = bits_for(OW);
  localparam int RW = bits_for(OH);
  localparam int TW = bits_for(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/conv2_out_tracker.sv
// Qualifies conv output pulses against a window and an output budget, and
// tags each accepted output with its raster row/column.
module conv2_out_tracker
  import conv2_pkg::*;
#(
  parameter int COLS = OW,
  parameter int ROWS = OH,
  parameter int CWID = bits_for(COLS),
  parameter int RWID = bits_for(ROWS),
  parameter int NWID = bits_for(COLS * ROWS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            window,
  input  logic            conv_valid_out,
  output logic            out_valid,
  output logic [RWID-1:0] out_row,
  output logic [CWID-1:0] out_col,
  output logic            full
);

  localparam int TOTAL = COLS * ROWS;

  logic [NWID-1:0] count;

  assign full      = (count == NWID'(TOTAL));
  assign out_valid = conv_valid_out && window && (count < NWID'(TOTAL));

  // The position stops advancing on the last output so it keeps naming it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count   <= '0;
      out_row <= '0;
      out_col <= '0;
    end else if (out_valid) begin
      count <= count + NWID'(1);
      if (count != NWID'(TOTAL - 1)) begin
        if (out_col == CWID'(COLS - 1)) begin
          out_col <= '0;
          out_row <= out_row + RWID'(1);
        end else begin
          out_col <= out_col + CWID'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv2_frame_ctrl.sv
// Frame sequencer for conv2: reads one raster frame from the feature-map
// buffer, streams it to the conv layer and counts/tags its valid outputs.
module conv2_frame_ctrl
  import conv2_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             src_valid,
  input  logic             hold,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [CH_IN-1:0] rd_data,
  output logic             conv_clr,
  output logic             conv_valid_in,
  output logic [CH_IN-1:0] conv_pixel,
  input  logic             conv_valid_out,
  output logic             out_valid,
  output logic [RW-1:0]    out_row,
  output logic [CW-1:0]    out_col,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t        state, state_next;
  logic          window;
  logic          full;
  logic          rd_en_q;
  logic          timeout;
  logic [TW-1:0] drain_cnt;

  assign timeout = (state == ST_DRAIN) && !full
                   && (drain_cnt == TW'(DRAIN_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Abort wins over every other transition, including a completing frame.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start && src_valid) state_next = ST_CLR;
        ST_CLR:   state_next = ST_FEED;
        ST_FEED:  if (rd_en && rd_addr == AW'(NPIX - 1)) state_next = ST_DRAIN;
        ST_DRAIN: if (full || timeout) state_next = ST_DONE;
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    rd_en    = 1'b0;
    conv_clr = 1'b0;
    done     = 1'b0;
    window   = 1'b0;
    busy     = (state != ST_IDLE);
    case (state)
      ST_CLR:   conv_clr = 1'b1;
      ST_FEED: begin
        rd_en  = !hold;
        window = 1'b1;
      end
      ST_DRAIN: window = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr   <= '0;
      rd_en_q   <= 1'b0;
      drain_cnt <= '0;
      err       <= 1'b0;
    end else begin
      rd_en_q <= rd_en && !abort;
      if (state == ST_CLR)
        rd_addr <= '0;
      else if (rd_en && rd_addr != AW'(NPIX - 1))
        rd_addr <= rd_addr + AW'(1);
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + TW'(1) : '0;
      if (state == ST_IDLE && state_next == ST_CLR)
        err <= 1'b0;
      else if (timeout && !abort)
        err <= 1'b1;
    end
  end

  // Buffer data arrives one cycle after the strobe, matching rd_en_q.
  assign conv_valid_in = rd_en_q;
  assign conv_pixel    = rd_en_q ? rd_data : '0;

  conv2_out_tracker u_tracker (
    .clk            (clk),
    .rst            (rst),
    .clr            (conv_clr),
    .window         (window),
    .conv_valid_out (conv_valid_out),
    .out_valid      (out_valid),
    .out_row        (out_row),
    .out_col        (out_col),
    .full           (full)
  );

endmodule

// File: tb/tb_conv2_frame_ctrl.sv
// Scoreboard bench for conv2_frame_ctrl: buffer and conv-layer models push
// expected results; a negedge monitor pops and compares.
module tb_conv2_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, src_valid = 1'b0, hold = 1'b0;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic       conv_clr, conv_valid_in;
  logic [7:0] conv_pixel;
  logic       conv_valid_out = 1'b0;
  logic       out_valid;
  logic [3:0] out_row, out_col;
  logic       busy, done, err;

  always #5 clk = ~clk;

  conv2_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .src_valid(src_valid),
    .hold(hold), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .conv_clr(conv_clr), .conv_valid_in(conv_valid_in), .conv_pixel(conv_pixel),
    .conv_valid_out(conv_valid_out), .out_valid(out_valid), .out_row(out_row),
    .out_col(out_col), .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] pix_of(input int a);
    return 8'(a * 37 + 11);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Feature-map buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= pix_of(int'(rd_addr));
  end

  // Conv-layer model: one output per pixel with row>=2 and col>=2, one cycle later.
  int  exp_q[$];
  int  m_pix = 0, m_emitted = 0;
  int  model_limit = 121;
  bit  model_extra = 1'b0;
  bit  m_extra_done = 1'b0;

  always @(posedge clk) begin
    conv_valid_out <= 1'b0;
    if (conv_clr) begin
      m_pix        <= 0;
      m_emitted    <= 0;
      m_extra_done <= 1'b0;
    end else if (conv_valid_in) begin
      m_pix <= m_pix + 1;
      if (m_pix / 13 >= 2 && m_pix % 13 >= 2 && m_emitted < model_limit) begin
        conv_valid_out <= 1'b1;
        m_emitted      <= m_emitted + 1;
        exp_q.push_back((m_pix / 13 - 2) * 16 + (m_pix % 13 - 2));
      end
    end else if (model_extra && !m_extra_done && conv_valid_out && m_emitted == 121) begin
      conv_valid_out <= 1'b1;
      m_extra_done   <= 1'b1;
    end
  end

  int clr_total = 0, done_total = 0;
  int rd_cnt, cvi_cnt, out_cnt, first_rd, last_rd, first_cvi, last_cvi;
  int exp_addr, exp_pix, first_pos;

  initial forever begin
    @(negedge clk);
    if (conv_clr) begin
      clr_total++;
      rd_cnt = 0; cvi_cnt = 0; out_cnt = 0; exp_addr = 0; exp_pix = 0;
      first_rd = 0; last_rd = 0; first_cvi = 0; last_cvi = 0; first_pos = -1;
    end
    if (rd_en) begin
      check("rd_addr", rd_addr, exp_addr);
      if (rd_cnt == 0) first_rd = cyc;
      last_rd = cyc;
      rd_cnt++;
      exp_addr++;
    end
    if (conv_valid_in) begin
      check("conv_pixel", conv_pixel, pix_of(exp_pix));
      if (cvi_cnt == 0) first_cvi = cyc;
      last_cvi = cyc;
      cvi_cnt++;
      exp_pix++;
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_valid_extra", out_valid, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("out_row", out_row, e / 16);
        check("out_col", out_col, e % 16);
        if (out_cnt == 0) first_pos = out_row * 16 + out_col;
        out_cnt++;
      end
    end
    if (done) done_total++;
  end

  task automatic wait_rd_addr(input int a);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 8'(a)) seen = 1'b1;
    end
    check("wait_rd_addr", seen, 1);
  endtask

  task automatic wait_clr(output int c);
    bit seen = 1'b0;
    c = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (conv_clr) begin seen = 1'b1; c = cyc; end
    end
    check("wait_conv_clr", seen, 1);
  endtask

  task automatic wait_done(output int c);
    bit seen = 1'b0;
    c = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; c = cyc; end
    end
    check("wait_done", seen, 1);
  endtask

  // Called at the negedge of the done cycle.
  task automatic frame_checks(input int clr0, input int exp_outs, input bit exp_err,
                              input int hold_len, input int done_cyc);
    check("clr_pulses", clr_total - clr0, 1);
    check("rd_count", rd_cnt, 169);
    check("rd_span", last_rd - first_rd, 168 + hold_len);
    check("cvi_count", cvi_cnt, 169);
    check("cvi_latency", first_cvi - first_rd, 1);
    check("cvi_last", last_cvi - last_rd, 1);
    check("out_count", out_cnt, exp_outs);
    check("scoreboard_empty", exp_q.size(), 0);
    check("first_pos", first_pos, 0);
    check("err_at_done", err, exp_err);
    check("busy_at_done", busy, 1);
    if (exp_err) check("drain_len", done_cyc - last_rd, 65);
    else         check("final_pos", out_row * 16 + out_col, 10 * 16 + 10);
    @(negedge clk);
    check("done_width", done, 0);
    check("busy_after", busy, 0);
    check("err_hold", err, exp_err);
  endtask

  task automatic run_frame(input int exp_outs, input bit exp_err, input int hold_len);
    int clr0, c, d;
    clr0 = clr_total;
    @(posedge clk); #1 src_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_clr(c);
    check("err_clear_on_start", err, 0);
    wait_done(d);
    frame_checks(clr0, exp_outs, exp_err, hold_len, d);
  endtask

  initial begin
    int c1, c2, d1, d2, clr_b, done_b;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_conv_clr", conv_clr, 0);
    check("rst_conv_valid_in", conv_valid_in, 0);
    check("rst_conv_pixel", conv_pixel, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: clean frame
    run_frame(121, 1'b0, 0);

    // 2: hold for 5 cycles while rd_addr = 40
    fork
      run_frame(121, 1'b0, 5);
      begin
        int hi = 0, lo = 0;
        wait_rd_addr(39);
        @(posedge clk); #1 hold = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("hold_rd_addr", rd_addr, 40);
          check("hold_rd_en", rd_en, 0);
          if (conv_valid_in) hi++; else lo++;
        end
        @(posedge clk); #1 hold = 1'b0;
        check("hold_cvi_one_more", hi, 1);
        check("hold_cvi_gap", lo, 4);
      end
    join

    // 3: start during FEED and held through DRAIN/DONE is ignored
    fork
      run_frame(121, 1'b0, 0);
      begin
        int dd;
        wait_rd_addr(80);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_rd_addr(168);
        @(posedge clk); #1 start = 1'b1;
        wait_done(dd);
        @(posedge clk); #1 start = 1'b0;
      end
    join
    clr_b = clr_total;
    repeat (3) @(negedge clk);
    check("start_in_done_busy", busy, 0);
    check("start_in_done_no_clr", clr_total - clr_b, 0);
    src_valid = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_src_busy", busy, 0);
    end
    check("no_src_no_clr", clr_total - clr_b, 0);
    src_valid = 1'b1;

    // 4: abort at rd_addr = 100, then a clean frame
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_rd_addr(99);
    @(posedge clk); #1 abort = 1'b1;
    done_b = done_total;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_cvi", conv_valid_in, 0);
    check("abort_out_valid", out_valid, 0);
    repeat (4) @(negedge clk);
    check("abort_no_done", done_total - done_b, 0);
    check("abort_err", err, 0);
    exp_q.delete();
    run_frame(121, 1'b0, 0);

    // 5: conv model short by one output -> drain timeout
    model_limit = 120;
    run_frame(120, 1'b1, 0);
    model_limit = 121;
    src_valid = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    check("err_sticky_busy", busy, 0);
    src_valid = 1'b1;
    model_extra = 1'b1;
    run_frame(121, 1'b0, 0);
    model_extra = 1'b0;

    // 6: back-to-back frames with start held high
    clr_b = clr_total;
    @(posedge clk); #1 start = 1'b1;
    wait_clr(c1);
    wait_done(d1);
    frame_checks(clr_b, 121, 1'b0, 0, d1);
    wait_clr(c2);
    check("b2b_clr_gap", c2 - d1, 2);
    @(posedge clk); #1 start = 1'b0;
    clr_b = clr_total - 1;
    wait_done(d2);
    frame_checks(clr_b, 121, 1'b0, 0, d2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
